// File: rtl/imem_responder.sv
// Instruction memory with an in-order, DEPTH-entry response FIFO and a loader write port.
// Define IMEM_ACCESS_FAULT_EN to flag misaligned or out-of-range fetches through RSP_ERR.
module imem_responder #(
    parameter int AW    = 20,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [63:0]   REQ_ADDR,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [31:0]   RSP_DATA,
    output logic          RSP_ERR,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [31:0]   WDATA
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem       [0:(1<<AW)-1];
    logic [31:0]   fifo_data [0:DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          accept;
    logic          pop;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;
    logic [31:0]   push_data;

    // Ready depends only on registered occupancy, so a full FIFO cannot accept during a pop.
    assign REQ_READY = (count < CW'(DEPTH));
    assign RSP_VALID = (count != '0);
    assign accept    = REQ_VALID & REQ_READY;
    assign pop       = RSP_VALID & RSP_READY;
    assign rd_idx    = REQ_ADDR[AW+1:2];
    assign rd_word   = (WE && (WADDR == rd_idx)) ? WDATA : mem[rd_idx];
    assign RSP_DATA  = RSP_VALID ? fifo_data[rd_ptr] : '0;

`ifdef IMEM_ACCESS_FAULT_EN
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] LIMIT = BASE + (64'd4 << AW);

    logic             push_err;
    logic [DEPTH-1:0] fifo_err;

    assign push_err  = (REQ_ADDR[1:0] != 2'b00)
                     | (REQ_ADDR < BASE)
                     | (REQ_ADDR >= LIMIT);
    assign push_data = push_err ? '0 : rd_word;
    assign RSP_ERR   = RSP_VALID & fifo_err[rd_ptr];

    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            fifo_err[wr_ptr] <= push_err;
        end
    end
`else
    logic unused_addr;

    assign unused_addr = ^{REQ_ADDR[63:AW+2], REQ_ADDR[1:0]};
    assign push_data   = rd_word;
    assign RSP_ERR     = 1'b0;
`endif

    // Memory has no reset so loaded code survives RST.
    always_ff @(posedge CLK) begin
        if (WE && !RST) begin
            mem[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && !RST) begin
            fifo_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, backpressure, streaming,
// write-first, reset flush and address aliasing/fault behaviour.
module tb_imem_responder;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [63:0] REQ_ADDR;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        WE;
    logic [19:0] WADDR;
    logic [31:0] WDATA;

    int total;
    int bad;

    logic [31:0] model [0:15];

    imem_responder #(.AW(20), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_ADDR  (REQ_ADDR),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [19:0] a, input logic [31:0] d);
        WE    = 1'b1;
        WADDR = a;
        WDATA = d;
        @(negedge CLK);
        WE    = 1'b0;
    endtask

    logic [63:0] a38 [0:2];
    logic [31:0] d38 [0:2];
    logic        e38 [0:2];

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_ADDR  = '0;
        RSP_READY = 1'b0;
        WE        = 1'b0;
        WADDR     = '0;
        WDATA     = '0;
        model[0]  = 32'h0000_0297;
        for (int i = 1; i < 16; i++) model[i] = 32'h1000_0000 + i;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_valid", RSP_VALID, 0);
        check("rst_data", RSP_DATA, 0);
        check("rst_err", RSP_ERR, 0);
        check("rst_ready", REQ_READY, 1);
        @(negedge CLK);

        for (int i = 0; i < 16; i++) load(20'(i), model[i]);
        load(20'h400, 32'hCAFE_0400);

        // single fetch, 1-cycle latency
        RSP_READY = 1'b1;
        REQ_VALID = 1'b1;
        REQ_ADDR  = BASE;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("lat_valid", RSP_VALID, 1);
        check("lat_data", RSP_DATA, 32'h0000_0297);
        check("lat_err", RSP_ERR, 0);
        @(negedge CLK);
        check("lat_drain", RSP_VALID, 0);

        // fill to full under backpressure
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1;
        REQ_ADDR  = BASE;
        for (int k = 1; k < 4; k++) begin
            @(negedge CLK);
            REQ_ADDR = BASE + 64'(4 * k);
        end
        @(negedge CLK);
        check("full_ready", REQ_READY, 0);
        check("full_valid", RSP_VALID, 1);
        check("full_head", RSP_DATA, model[0]);
        REQ_ADDR = BASE + 64'd16;
        @(negedge CLK);
        check("full_hold_ready", REQ_READY, 0);
        check("full_hold_head", RSP_DATA, model[0]);
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("full_pop1", RSP_DATA, model[1]);
        check("full_ready_back", REQ_READY, 1);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("full_pop2", RSP_DATA, model[2]);
        @(negedge CLK);
        check("full_pop3", RSP_DATA, model[3]);
        @(negedge CLK);
        check("fifth_valid", RSP_VALID, 1);
        check("fifth_data", RSP_DATA, model[4]);
        @(negedge CLK);
        check("fifth_drain", RSP_VALID, 0);

        // back-to-back stream of 16, pointers wrap
        REQ_VALID = 1'b1;
        for (int i = 0; i < 16; i++) begin
            REQ_ADDR = BASE + 64'(4 * i);
            @(negedge CLK);
            check($sformatf("strm_v%0d", i), RSP_VALID, 1);
            check($sformatf("strm_d%0d", i), RSP_DATA, model[i]);
            check($sformatf("strm_r%0d", i), REQ_READY, 1);
        end
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("strm_drain", RSP_VALID, 0);

        // write-first collision
        WE        = 1'b1;
        WADDR     = 20'd8;
        WDATA     = 32'hDEAD_BEEF;
        REQ_VALID = 1'b1;
        REQ_ADDR  = BASE + 64'h20;
        @(negedge CLK);
        WE        = 1'b0;
        REQ_VALID = 1'b0;
        model[8]  = 32'hDEAD_BEEF;
        check("wf_data", RSP_DATA, 32'hDEAD_BEEF);
        @(negedge CLK);

        // buffered entry unaffected by a later write
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1;
        REQ_ADDR  = BASE + 64'd20;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        WE        = 1'b1;
        WADDR     = 20'd5;
        WDATA     = 32'h5555_AAAA;
        @(negedge CLK);
        WE = 1'b0;
        check("late_wr_head", RSP_DATA, model[5]);
        model[5]  = 32'h5555_AAAA;
        RSP_READY = 1'b1;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("late_wr_new", RSP_DATA, model[5]);
        @(negedge CLK);

        // reset flush with three buffered requests
        RSP_READY = 1'b0;
        REQ_VALID = 1'b1;
        for (int k = 1; k < 4; k++) begin
            REQ_ADDR = BASE + 64'(4 * k);
            @(negedge CLK);
        end
        check("pre_rst_valid", RSP_VALID, 1);
        RST   = 1'b1;
        WE    = 1'b1;
        WADDR = 20'd1;
        WDATA = 32'h0000_0BAD;
        #1;
        check("rst_async_valid", RSP_VALID, 0);
        @(negedge CLK);
        RST       = 1'b0;
        WE        = 1'b0;
        REQ_VALID = 1'b0;
        #1;
        check("rst2_valid", RSP_VALID, 0);
        check("rst2_ready", REQ_READY, 1);
        check("rst2_data", RSP_DATA, 0);
        RSP_READY = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check($sformatf("no_stale%0d", k), RSP_VALID, 0);
        end
        REQ_VALID = 1'b1;
        REQ_ADDR  = BASE + 64'd4;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check("reread_valid", RSP_VALID, 1);
        check("reread_data", RSP_DATA, model[1]);
        @(negedge CLK);

        // misaligned / out-of-range addresses
        a38[0] = BASE + 64'd2;
        a38[1] = 64'h0000_0000_0000_1000;
        a38[2] = BASE + 64'd4;
`ifdef IMEM_ACCESS_FAULT_EN
        d38[0] = 32'h0;  e38[0] = 1'b1;
        d38[1] = 32'h0;  e38[1] = 1'b1;
        d38[2] = model[1]; e38[2] = 1'b0;
`else
        d38[0] = model[0];     e38[0] = 1'b0;
        d38[1] = 32'hCAFE_0400; e38[1] = 1'b0;
        d38[2] = model[1];     e38[2] = 1'b0;
`endif
        REQ_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            REQ_ADDR = a38[i];
            @(negedge CLK);
            check($sformatf("addr_v%0d", i), RSP_VALID, 1);
            check($sformatf("addr_d%0d", i), RSP_DATA, d38[i]);
            check($sformatf("addr_e%0d", i), RSP_ERR, e38[i]);
        end
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check("end_drain", RSP_VALID, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter AW, default 20, word-address width (memory holds 2^AW 32-bit words, base 0x0000_0000_8000_0000).
REQ-002 SHALL have parameter DEPTH, default 4, response-buffer entries (power of two, >=2).
REQ-003 SHALL have CLK  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have REQ_VALID  in  1  fetch request valid.
REQ-006 SHALL have REQ_READY  out  1  request accepted when VALID&READY at rising edge.
REQ-007 SHALL have REQ_ADDR  in  64  fetch byte address (pc).
REQ-008 SHALL have RSP_VALID  out  1  response valid.
REQ-009 SHALL have RSP_READY  in  1  response consumed when VALID&READY at rising edge.
REQ-010 SHALL have RSP_DATA  out  32  instruction word.
REQ-011 SHALL have RSP_ERR  out  1  access fault flag.
REQ-012 SHALL have WE  in  1  loader word-write enable.
REQ-013 SHALL have WADDR  in  AW  loader word address.
REQ-014 SHALL have WDATA  in  32  loader write data.

Function
REQ-015 Word index SHALL be REQ_ADDR[AW+1:2]; higher and lower bits ignored unless REQ-031 applies.
REQ-016 Accepted request SHALL be read and pushed into a DEPTH-entry FIFO at the accepting edge; RSP_VALID SHALL rise the following cycle when the FIFO was empty (1-cycle latency).
REQ-017 Responses SHALL return strictly in request order.
REQ-018 RSP_VALID SHALL equal FIFO non-empty; RSP_DATA/RSP_ERR SHALL be the head entry and stay stable while RSP_VALID & !RSP_READY.
REQ-019 Occupancy counter SHALL update +1 on accept, -1 on pop, unchanged on both or neither.
REQ-020 REQ_READY SHALL be (count < DEPTH), registered-state only, with no combinational path from RSP_READY or REQ_VALID.
REQ-021 With FIFO full, an accept SHALL NOT occur even if a pop occurs the same edge; REQ_READY rises the cycle after the pop.
REQ-022 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-023 WE SHALL write mem[WADDR] at the rising edge regardless of request traffic.
REQ-024 Write and accepted read to the same word at one edge SHALL return WDATA (write-first).
REQ-025 Entries already in the FIFO SHALL NOT be altered by later writes.
REQ-026 A back-to-back stream (REQ_VALID and RSP_READY held high) SHALL sustain one accept and one response per cycle.

Reset
REQ-027 RST high SHALL asynchronously clear count and pointers, giving RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, REQ_READY=1 after deassertion.
REQ-028 RST SHALL NOT clear memory contents.
REQ-029 RST mid-operation SHALL discard all buffered responses; no response for a pre-reset request appears afterwards.
REQ-030 Requests and writes SHALL be ignored while RST is high.

Configuration
REQ-031 With IMEM_ACCESS_FAULT_EN defined, an accepted request with REQ_ADDR[1:0]!=0, or REQ_ADDR outside [0x8000_0000, 0x8000_0000+4*2^AW), SHALL return RSP_ERR=1, RSP_DATA=0, occupying one FIFO slot in order.
REQ-032 Without IMEM_ACCESS_FAULT_EN, RSP_ERR SHALL be constant 0 and all addresses SHALL alias per REQ-015.

Verification
REQ-033 Load mem[0]=0x0000_0297 via WE, request 0x8000_0000, RSP_READY=1 -> RSP_VALID next cycle, RSP_DATA=0x0000_0297, RSP_ERR=0.
REQ-034 RSP_READY=0, issue 5 requests to 0x8000_0000..0x8000_0010 -> 4 accepted, REQ_READY=0 after 4th; raise RSP_READY -> words 0..3 in order, then 5th accepted.
REQ-035 Stream 16 sequential addresses, RSP_READY=1 -> 16 responses on 16 consecutive cycles, pointers wrap, data matches.
REQ-036 WE to word 8 with 0xDEAD_BEEF same edge as request 0x8000_0020 -> RSP_DATA=0xDEAD_BEEF.
REQ-037 Three requests buffered, assert RST for 1 cycle -> RSP_VALID=0, REQ_READY=1, no stale responses; memory data intact on re-read.
REQ-038 With IMEM_ACCESS_FAULT_EN, request 0x8000_0002 then 0x0000_1000 then 0x8000_0004 -> RSP_ERR=1,1,0 in order; without macro, 0x0000_1000 returns mem word 0x400.
